// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the sysid slave.
// Valid/ready rule: a read is presented while avm_read=1 and completes in the first cycle avm_waitrequest=0.
interface sysid_check_ctrl_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid checker: reads the ID word (and optionally the timestamp) and gates the motor enable.
// Optional timestamp read/compare is built when SYSID_CHECK_TS_EN is defined.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID = 32'd67108864,
    parameter logic [31:0] EXPECTED_TS = 32'd1414746992,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    sysid_check_ctrl_if.master        avm,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [1:0]                fail_code,
    output logic [31:0]               id_value,
    output logic [31:0]               ts_value,
    output logic                      motor_enable,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        PASS  = 3'd3,
        FAIL  = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    localparam logic [3:0]  MAX_RETRY_C = 4'(MAX_RETRY);

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ID      = 2'd1;
    localparam logic [1:0] FC_TS      = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic        holdoff_q, holdoff_d;
    logic        done_q, done_d;
    logic [1:0]  fail_code_q, fail_code_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic in_read;
    logic read_active;
    logic grant;
    logic expire;

    always_comb begin
        in_read     = (state_q == RD_ID) || (state_q == RD_TS);
        // holdoff_q marks the one idle cycle between a timed-out attempt and its retry
        read_active = in_read && !holdoff_q;
        grant       = read_active && !avm.avm_waitrequest;
        expire      = read_active && avm.avm_waitrequest && (wait_cnt_q >= TIMEOUT_M1);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = 16'd0;
        retry_cnt_d = retry_cnt_q;
        holdoff_d   = 1'b0;
        done_d      = 1'b0;
        fail_code_d = fail_code_q;
        id_value_d  = id_value_q;
        ts_value_d  = ts_value_q;

        if (read_active && avm.avm_waitrequest && !expire && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                state_d     = RD_ID;
                retry_cnt_d = 4'd0;
            end

            RD_ID: begin
                if (grant) begin
                    id_value_d = avm.avm_readdata;
                    if (avm.avm_readdata == EXPECTED_ID) begin
`ifdef SYSID_CHECK_TS_EN
                        state_d = RD_TS;
`else
                        state_d = PASS;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d     = FAIL;
                        fail_code_d = FC_ID;
                        done_d      = 1'b1;
                    end
                end
            end

`ifdef SYSID_CHECK_TS_EN
            RD_TS: begin
                if (grant) begin
                    ts_value_d = avm.avm_readdata;
                    if (avm.avm_readdata == EXPECTED_TS) begin
                        state_d = PASS;
                    end else begin
                        state_d     = FAIL;
                        fail_code_d = FC_TS;
                    end
                    done_d = 1'b1;
                end
            end
`endif

            PASS, FAIL: begin
                if (start) begin
                    state_d     = RD_ID;
                    fail_code_d = FC_NONE;
                    retry_cnt_d = 4'd0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout handling is shared by both read states; retry_cnt never exceeds MAX_RETRY.
        if (expire) begin
            if (retry_cnt_q >= MAX_RETRY_C) begin
                state_d     = FAIL;
                fail_code_d = FC_TIMEOUT;
                done_d      = 1'b1;
            end else begin
                retry_cnt_d = retry_cnt_q + 4'd1;
                holdoff_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 16'd0;
            retry_cnt_q <= 4'd0;
            holdoff_q   <= 1'b0;
            done_q      <= 1'b0;
            fail_code_q <= FC_NONE;
            id_value_q  <= 32'd0;
            ts_value_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            holdoff_q   <= holdoff_d;
            done_q      <= done_d;
            fail_code_q <= fail_code_d;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
        end
    end

    assign avm.avm_read    = read_active;
    assign avm.avm_address = (state_q == RD_TS);
    assign busy            = in_read;
    assign done            = done_q;
    assign pass            = (state_q == PASS);
    assign motor_enable    = (state_q == PASS);
    assign fail_code       = fail_code_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Self-checking bench for sysid_check_ctrl (TIMEOUT=4, MAX_RETRY=2) with an Avalon slave model.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd67108864;
    localparam logic [31:0] EXP_TS = 32'd1414746992;
    localparam logic [31:0] BAD_ID = 32'h0400_0001;
`ifdef SYSID_CHECK_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif
    localparam logic [31:0] BOOT_TS = TS_EN ? EXP_TS : 32'd0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, motor_enable;
    logic [1:0]  fail_code;
    logic [31:0] id_value, ts_value;
    logic [2:0]  dbg_state;

    sysid_check_ctrl_if bus ();

    sysid_check_ctrl #(
        .TIMEOUT   (4),
        .MAX_RETRY (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .avm          (bus.master),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .id_value     (id_value),
        .ts_value     (ts_value),
        .motor_enable (motor_enable),
        .dbg_state    (dbg_state)
    );

    always #5 clock = ~clock;

    // Slave model: per-address stall length, or hang forever.
    logic [31:0] id_word = EXP_ID;
    logic [31:0] ts_word = EXP_TS;
    int          stall_id = 0;
    int          stall_ts = 0;
    bit          hang = 1'b0;
    int          stall_cnt = 0;

    always @(posedge clock) begin
        if (bus.avm_read && bus.avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    assign bus.avm_waitrequest = bus.avm_read && (hang || (stall_cnt < (bus.avm_address ? stall_ts : stall_id)));
    assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

    int          n_vec = 0;
    int          n_err = 0;
    logic [66:0] exp_q[$];
    int          addr1_cycles = 0;
    int          done_count = 0;
    int          run_len = 0;
    int          run_q[$];
    logic        prev_read = 1'b0;

    // Bus monitor and scoreboard, sampled 2ns after each rising edge.
    always @(posedge clock) begin
        logic [66:0] exp_v;
        logic [66:0] act_v;
        #2;
        if (bus.avm_read && bus.avm_address) addr1_cycles++;
        if (bus.avm_read) run_len++;
        else if (prev_read) begin
            run_q.push_back(run_len);
            run_len = 0;
        end
        prev_read = bus.avm_read;
        if (done === 1'b1) begin
            done_count++;
            n_vec++;
            act_v = {pass, fail_code, id_value, ts_value};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_unexpected_done: got %h expected no result", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL scoreboard_result: got %h expected %h", act_v, exp_v);
                end
            end
        end
    end

    task automatic wait_for_done(input int budget, output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge clock);
            cycles++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({bus.avm_read, bus.avm_address, busy, done, pass, motor_enable, fail_code, dbg_state} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0", {bus.avm_read, bus.avm_address, busy, done, pass, motor_enable, fail_code, dbg_state});
        end
        n_vec++;
        if (id_value !== 32'd0) begin
            n_err++;
            $display("FAIL reset_id_value: got %h expected 0", id_value);
        end
        n_vec++;
        if (ts_value !== 32'd0) begin
            n_err++;
            $display("FAIL reset_ts_value: got %h expected 0", ts_value);
        end
    endtask

    task automatic test_clean_boot();
        bit seen;
        int cyc;
        id_word = EXP_ID;
        ts_word = EXP_TS;
        stall_id = 0;
        stall_ts = 0;
        exp_q.push_back({1'b1, 2'd0, EXP_ID, BOOT_TS});
        reset = 1'b0;
        wait_for_done(20, seen, cyc);
        n_vec++;
        if (!seen || cyc != (TS_EN ? 3 : 2)) begin
            n_err++;
            $display("FAIL boot_done_cycle: got seen=%0d cycle=%0d expected cycle %0d", seen, cyc, TS_EN ? 3 : 2);
        end
        n_vec++;
        if ({motor_enable, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL boot_motor_busy: got %b expected 10", {motor_enable, busy});
        end
        @(negedge clock);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL boot_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_recheck();
        bit seen;
        int cyc;
        int snap;
        ts_word = 32'd0;
        stall_id = 3;
        if (TS_EN) exp_q.push_back({1'b0, 2'd2, EXP_ID, 32'd0});
        else exp_q.push_back({1'b1, 2'd0, EXP_ID, 32'd0});
        snap = done_count;
        pulse_start();
        n_vec++;
        if ({pass, busy, dbg_state} !== {1'b0, 1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL recheck_entry: got pass/busy/state %b expected 0_1_001", {pass, busy, dbg_state});
        end
        pulse_start();
        wait_for_done(30, seen, cyc);
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL recheck_done: got no done expected done within 30 cycles");
        end
        repeat (4) @(negedge clock);
        n_vec++;
        if (done_count != snap + 1 || busy !== 1'b0 || dbg_state !== (TS_EN ? 3'd4 : 3'd3)) begin
            n_err++;
            $display("FAIL recheck_start_ignored: got dones=%0d busy=%b state=%0d expected dones=1 busy=0 state=%0d",
                     done_count - snap, busy, dbg_state, TS_EN ? 4 : 3);
        end
        stall_id = 0;
    endtask

    task automatic test_id_mismatch();
        bit seen;
        int cyc;
        id_word = BAD_ID;
        ts_word = EXP_TS;
        addr1_cycles = 0;
        exp_q.push_back({1'b0, 2'd1, BAD_ID, 32'd0});
        pulse_start();
        wait_for_done(20, seen, cyc);
        repeat (2) @(negedge clock);
        n_vec++;
        if (!seen || addr1_cycles != 0) begin
            n_err++;
            $display("FAIL idmis_no_ts_read: got seen=%0d addr1_cycles=%0d expected seen=1 addr1_cycles=0", seen, addr1_cycles);
        end
        n_vec++;
        if ({motor_enable, fail_code, dbg_state} !== {1'b0, 2'd1, 3'd4}) begin
            n_err++;
            $display("FAIL idmis_state: got motor/fc/state %b expected 0_01_100", {motor_enable, fail_code, dbg_state});
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int cyc;
        int snap;
        hang = 1'b1;
        id_word = EXP_ID;
        run_q.delete();
        run_len = 0;
        snap = done_count;
        exp_q.push_back({1'b0, 2'd3, BAD_ID, 32'd0});
        pulse_start();
        wait_for_done(60, seen, cyc);
        repeat (3) @(negedge clock);
        n_vec++;
        if (!seen || done_count != snap + 1) begin
            n_err++;
            $display("FAIL timeout_done_once: got seen=%0d dones=%0d expected seen=1 dones=1", seen, done_count - snap);
        end
        n_vec++;
        if (run_q.size() != 3) begin
            n_err++;
            $display("FAIL timeout_attempts: got %0d expected 3", run_q.size());
        end
        foreach (run_q[i]) begin
            n_vec++;
            if (run_q[i] != 4) begin
                n_err++;
                $display("FAIL timeout_attempt_len[%0d]: got %0d expected 4", i, run_q[i]);
            end
        end
        hang = 1'b0;
    endtask

    task automatic test_stall_grant();
        bit seen;
        int cyc;
        id_word = EXP_ID;
        ts_word = EXP_TS;
        stall_ts = 3;
        addr1_cycles = 0;
        run_q.delete();
        run_len = 0;
        exp_q.push_back({1'b1, 2'd0, EXP_ID, BOOT_TS});
        pulse_start();
        wait_for_done(30, seen, cyc);
        repeat (2) @(negedge clock);
        n_vec++;
        if (!seen || addr1_cycles != (TS_EN ? 4 : 0)) begin
            n_err++;
            $display("FAIL stall_addr1_cycles: got seen=%0d cycles=%0d expected seen=1 cycles=%0d", seen, addr1_cycles, TS_EN ? 4 : 0);
        end
        n_vec++;
        if (run_q.size() != 1 || (run_q.size() == 1 && run_q[0] != (TS_EN ? 5 : 1))) begin
            n_err++;
            $display("FAIL stall_read_run: got runs=%0d expected one run of %0d", run_q.size(), TS_EN ? 5 : 1);
        end
        n_vec++;
        if ({pass, motor_enable} !== 2'b11) begin
            n_err++;
            $display("FAIL stall_pass: got %b expected 11", {pass, motor_enable});
        end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        bit hit;
        int cyc;
        logic [2:0] stall_state;
        stall_state = TS_EN ? 3'd2 : 3'd1;
        if (TS_EN) stall_ts = 3;
        else stall_id = 3;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (dbg_state === stall_state && bus.avm_waitrequest === 1'b1) hit = 1'b1;
            else @(negedge clock);
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL rstmid_reach_stall: got no stall expected stall in state %0d", stall_state);
        end
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({bus.avm_read, bus.avm_address, busy, done, pass, motor_enable, fail_code, dbg_state} !== 11'd0) begin
            n_err++;
            $display("FAIL rstmid_ctrl: got %b expected 0", {bus.avm_read, bus.avm_address, busy, done, pass, motor_enable, fail_code, dbg_state});
        end
        n_vec++;
        if ({id_value, ts_value} !== 64'd0) begin
            n_err++;
            $display("FAIL rstmid_values: got %h expected 0", {id_value, ts_value});
        end
        @(negedge clock);
        exp_q.push_back({1'b1, 2'd0, EXP_ID, BOOT_TS});
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({dbg_state, bus.avm_read, bus.avm_address} !== {3'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_restart: got state/read/addr %b expected 001_1_0", {dbg_state, bus.avm_read, bus.avm_address});
        end
        wait_for_done(30, seen, cyc);
        n_vec++;
        if (!seen || cyc + 1 != (TS_EN ? 6 : 5)) begin
            n_err++;
            $display("FAIL rstmid_done_cycle: got seen=%0d cycle=%0d expected cycle %0d", seen, cyc + 1, TS_EN ? 6 : 5);
        end
        stall_id = 0;
        stall_ts = 0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_clean_boot();
        test_recheck();
        test_id_mismatch();
        test_timeout();
        test_stall_grant();
        test_reset_mid_read();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
